// File: rtl/tri_bus_arbiter_if.sv
// Shared 4-bit tri-state bus control signals: requests in, one-hot grant and status out.
interface tri_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout;

  // Requesters drive req; the arbiter drives everything else.
  modport master (output req, input gnt, owner, bus_busy, timeout);
  modport slave  (input req, output gnt, owner, bus_busy, timeout);
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with bounded tenure and
// a dead turnaround gap between owners so drivers never overlap.
module tri_bus_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  tri_bus_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TURN_W = 4;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state_q, state_nxt;
  logic [N_REQ-1:0]    gnt_q, gnt_nxt;
  logic [IDX_W-1:0]    owner_q, owner_nxt;
  logic [IDX_W-1:0]    last_q, last_nxt;
  logic [HOLD_W-1:0]   hold_q, hold_nxt;
  logic [TURN_W-1:0]   turn_q, turn_nxt;
  logic                timeout_q, timeout_nxt;

  logic                found;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    idx;
  logic                arb;

  // Search starts just past the last owner; IDX_W-bit addition wraps mod N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = last_q + IDX_W'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    gnt_nxt     = gnt_q;
    owner_nxt   = owner_q;
    last_nxt    = last_q;
    hold_nxt    = hold_q;
    turn_nxt    = turn_q;
    timeout_nxt = 1'b0;
    arb         = 1'b0;

    unique case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (!bus.req[owner_q]) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          turn_nxt  = TURN_W'(TURN_CYCLES);
        end else if (hold_q >= HOLD_W'(MAX_HOLD)) begin
          state_nxt   = TURN;
          gnt_nxt     = '0;
          turn_nxt    = TURN_W'(TURN_CYCLES);
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_q + HOLD_W'(1);
        end
      end
      TURN: begin
        if (turn_q <= TURN_W'(1)) arb = 1'b1;
        else                      turn_nxt = turn_q - TURN_W'(1);
      end
      default: state_nxt = IDLE;
    endcase

    // Arbitration edge: shared by IDLE and the final turnaround cycle.
    if (arb) begin
      turn_nxt = '0;
      gnt_nxt  = '0;
      if (found) begin
        state_nxt       = GRANT;
        gnt_nxt[winner] = 1'b1;
        owner_nxt       = winner;
        last_nxt        = winner;
        hold_nxt        = HOLD_W'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      hold_q    <= '0;
      turn_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      gnt_q     <= gnt_nxt;
      owner_q   <= owner_nxt;
      last_q    <= last_nxt;
      hold_q    <= hold_nxt;
      turn_q    <= turn_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = |gnt_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench: drivers queue hand-computed post-edge expectations,
// per-DUT monitors pop and compare one entry after each rising edge.
module tb_tri_bus_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic       timeout;
  } exp_t;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  tri_bus_arbiter_if bus1 ();
  tri_bus_arbiter_if bus2 ();

  tri_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_dut1 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus1)
  );

  tri_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(3)) u_dut3 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus2)
  );

  exp_t q1[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_val);
    checks++;
    if (act !== req_val) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, req_val, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Monitors: compare each DUT's registered outputs just after every edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("gnt_t1", {4'd0, bus1.gnt}, {4'd0, e.gnt});
      check("timeout_t1", {7'd0, bus1.timeout}, {7'd0, e.timeout});
      check("busy_t1", {7'd0, bus1.bus_busy}, {7'd0, |e.gnt});
      if (e.gnt != 4'd0) check("owner_t1", {6'd0, bus1.owner}, {6'd0, idx_of(e.gnt)});
    end
  end

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("gnt_t3", {4'd0, bus2.gnt}, {4'd0, e.gnt});
      check("timeout_t3", {7'd0, bus2.timeout}, {7'd0, e.timeout});
      check("busy_t3", {7'd0, bus2.bus_busy}, {7'd0, |e.gnt});
      if (e.gnt != 4'd0) check("owner_t3", {6'd0, bus2.owner}, {6'd0, idx_of(e.gnt)});
    end
  end

  // At most one grant bit, every cycle, on both instances.
  always @(negedge clock) begin
    checks++;
    a_onehot: assert ($onehot0(bus1.gnt) && $onehot0(bus2.gnt)) else begin
      failures++;
      $display("FAIL onehot gnt1=%b gnt3=%b t=%0t", bus1.gnt, bus2.gnt, $time);
    end
  end

  task automatic step1(input logic [3:0] r, input logic [3:0] g, input logic t);
    @(negedge clock);
    bus1.req = r;
    q1.push_back({g, t});
  endtask

  task automatic step2(input logic [3:0] r, input logic [3:0] g, input logic t);
    @(negedge clock);
    bus2.req = r;
    q2.push_back({g, t});
  endtask

  task automatic check_reset(input string tag);
    check({"rst_gnt_", tag}, {bus1.gnt, bus2.gnt}, 8'h00);
    check({"rst_busy_", tag}, {6'd0, bus1.bus_busy, bus2.bus_busy}, 8'h00);
    check({"rst_timeout_", tag}, {6'd0, bus1.timeout, bus2.timeout}, 8'h00);
    check({"rst_owner_", tag}, {4'd0, bus1.owner, bus2.owner}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus1.req = 4'd0;
    bus2.req = 4'd0;
    #2;
    check_reset("power_on");
    @(posedge clock);
    #2 clear_n = 1'b1;

    // Two requesters: 0 wins after reset; dropping req[0] hands over to 2 after one dead cycle.
    step1(4'b0101, 4'b0001, 1'b0);
    step1(4'b0101, 4'b0001, 1'b0);
    step1(4'b0100, 4'b0000, 1'b0);
    step1(4'b0100, 4'b0100, 1'b0);
    step1(4'b0100, 4'b0100, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);

    // Fresh reset, all four requesting, two-cycle tenures: order 0,1,2,3,0.
    @(posedge clock);
    #3 clear_n = 1'b0;
    #1 check_reset("between_tests");
    @(posedge clock);
    #2 clear_n = 1'b1;
    step1(4'b1111, 4'b0001, 1'b0);
    step1(4'b1111, 4'b0001, 1'b0);
    step1(4'b1110, 4'b0000, 1'b0);
    step1(4'b1111, 4'b0010, 1'b0);
    step1(4'b1111, 4'b0010, 1'b0);
    step1(4'b1101, 4'b0000, 1'b0);
    step1(4'b1111, 4'b0100, 1'b0);
    step1(4'b1111, 4'b0100, 1'b0);
    step1(4'b1011, 4'b0000, 1'b0);
    step1(4'b1111, 4'b1000, 1'b0);
    step1(4'b1111, 4'b1000, 1'b0);
    step1(4'b0111, 4'b0000, 1'b0);
    step1(4'b1111, 4'b0001, 1'b0);
    step1(4'b1111, 4'b0001, 1'b0);
    step1(4'b1110, 4'b0000, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);

    // Sole requester 2 held forever: 8 grant cycles, timeout, one gap, re-grant, repeat.
    for (int rep = 0; rep < 2; rep++) begin
      repeat (8) step1(4'b0100, 4'b0100, 1'b0);
      step1(4'b0100, 4'b0000, 1'b1);
    end
    step1(4'b0000, 4'b0000, 1'b0);

    // Owner 1 times out while 3 waits: next grant goes to 3, not back to 1.
    step1(4'b0010, 4'b0010, 1'b0);
    repeat (7) step1(4'b1010, 4'b0010, 1'b0);
    step1(4'b1010, 4'b0000, 1'b1);
    step1(4'b1010, 4'b1000, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);

    // Asynchronous reset mid-tenure drops gnt at once; first edge after release grants 3.
    step1(4'b0001, 4'b0001, 1'b0);
    step1(4'b0001, 4'b0001, 1'b0);
    @(posedge clock);
    #3 clear_n = 1'b0;
    #1 check_reset("mid_tenure");
    bus1.req = 4'b1000;
    @(posedge clock);
    #2 clear_n = 1'b1;
    step1(4'b1000, 4'b1000, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);
    step1(4'b0000, 4'b0000, 1'b0);

    // Three-cycle turnaround: req[1] waits through exactly three dead cycles.
    step2(4'b0011, 4'b0001, 1'b0);
    step2(4'b0011, 4'b0001, 1'b0);
    step2(4'b0010, 4'b0000, 1'b0);
    step2(4'b0010, 4'b0000, 1'b0);
    step2(4'b0010, 4'b0000, 1'b0);
    step2(4'b0010, 4'b0010, 1'b0);
    step2(4'b0000, 4'b0000, 1'b0);
    repeat (3) step2(4'b0000, 4'b0000, 1'b0);

    repeat (3) @(posedge clock);
    #2;
    check("queues_drained", 8'(q1.size() + q2.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
